// File: rtl/bpu_btb_pkg.sv
// Shared branch-prediction definitions.
// Holds the fetch next-PC select encoding, the 2-bit direction-counter constants,
// the BTB entry field widths and the BTB sweep FSM state type.
package bpu_btb_pkg;

    // Fetch next-PC source select.
    typedef enum logic [1:0] {
        BrSelSeq      = 2'b00,
        BrSelBtb      = 2'b01,
        BrSelRedirect = 2'b10
    } br_sel_e;

    // 2-bit direction counter encodings: strongly/weakly not-taken, weakly/strongly taken.
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Entry field widths (the tag width depends on the index width and is derived in the BTB).
    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned OFF_W = 2;  // byte offset bits below the index

    typedef enum logic {
        StInit,
        StRun
    } btb_state_e;

endpackage

// File: rtl/bpu_btb_if.sv
// Fetch-side lookup / update bus of the branch target buffer.
//   pc, pred_taken, pred_target     : combinational lookup for the fetch PC
//   update, update_pc, act_taken,
//   act_target                      : one resolved control transfer per cycle
//   inv_all                         : invalidate the whole table (pulse)
//   init_busy                       : table sweep in progress
// master = fetch / decode side, slave = BTB.
interface bpu_btb_if;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update;
    logic [31:0] update_pc;
    logic        act_taken;
    logic [31:0] act_target;
    logic        inv_all;
    logic        init_busy;

    modport master (
        output pc, update, update_pc, act_taken, act_target, inv_all,
        input  pred_taken, pred_target, init_busy
    );

    modport slave (
        input  pc, update, update_pc, act_taken, act_target, inv_all,
        output pred_taken, pred_target, init_busy
    );
endinterface

// File: rtl/bpu_sat_cnt2.sv
// Combinational 2-bit saturating up/down counter step.
//   cnt      : current counter value
//   up       : 1 = increment, 0 = decrement
//   cnt_next : next value, clamped at 2'b00 and 2'b11
module bpu_sat_cnt2
    import bpu_btb_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       up,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (up) begin
            if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : lookup/update/invalidate bus (slave side), see bpu_btb_if
// Lookups are combinational. Updates are read-modify-write into a one-entry write
// buffer that is written to the table one cycle later; both the lookup and the update
// read paths forward from that buffer. After reset or inv_all a sweep clears one valid
// bit per cycle; during the sweep predictions are forced off and updates dropped.
module bpu_btb
    import bpu_btb_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned TAG_W    = 32 - IDX_W - 2,
    parameter logic [1:0]  CNT_INIT = CNT_WT
) (
    input  logic       clk,
    input  logic       rst_n,
    bpu_btb_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    // Table storage; only valid bits are ever cleared.
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [CNT_W-1:0] cnt_mem [DEPTH];
    logic [PC_W-1:0]  tgt_mem [DEPTH];

    btb_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    // Write buffer: a buffered entry is always valid, so no valid field is kept.
    logic             wb_vld_q, wb_vld_d;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
    logic [PC_W-1:0]  wb_tgt_q, wb_tgt_d;

    logic running;
    assign running = rst_n && (state_q == StRun);

    // Byte-offset bits play no part in indexing.
    logic unused_off;
    assign unused_off = ^{bus.pc[OFF_W-1:0], bus.update_pc[OFF_W-1:0]};

    // ------------------------------------------------------------------ lookup
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag_e;
    logic [CNT_W-1:0] lk_cnt;
    logic [PC_W-1:0]  lk_tgt;
    logic             lk_hit;

    assign lk_idx = bus.pc[IDX_W+OFF_W-1:OFF_W];
    assign lk_tag = bus.pc[PC_W-1:IDX_W+OFF_W];

    always_comb begin
        lk_valid = valid_q[lk_idx];
        lk_tag_e = tag_mem[lk_idx];
        lk_cnt   = cnt_mem[lk_idx];
        lk_tgt   = tgt_mem[lk_idx];
        if (wb_vld_q && (wb_idx_q == lk_idx)) begin
            lk_valid = 1'b1;
            lk_tag_e = wb_tag_q;
            lk_cnt   = wb_cnt_q;
            lk_tgt   = wb_tgt_q;
        end
    end

    assign lk_hit          = lk_valid && (lk_tag_e == lk_tag);
    assign bus.pred_taken  = running && lk_hit && lk_cnt[1];
    assign bus.pred_target = bus.pred_taken ? lk_tgt : '0;
    assign bus.init_busy   = !rst_n || (state_q == StInit);

    // --------------------------------------------------------- update (RMW)
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_valid;
    logic [TAG_W-1:0] up_tag_e;
    logic [CNT_W-1:0] up_cnt;
    logic [PC_W-1:0]  up_tgt;
    logic             up_hit;
    logic             up_accept;
    logic [CNT_W-1:0] up_cnt_next;

    assign up_idx = bus.update_pc[IDX_W+OFF_W-1:OFF_W];
    assign up_tag = bus.update_pc[PC_W-1:IDX_W+OFF_W];

    always_comb begin
        up_valid = valid_q[up_idx];
        up_tag_e = tag_mem[up_idx];
        up_cnt   = cnt_mem[up_idx];
        up_tgt   = tgt_mem[up_idx];
        if (wb_vld_q && (wb_idx_q == up_idx)) begin
            up_valid = 1'b1;
            up_tag_e = wb_tag_q;
            up_cnt   = wb_cnt_q;
            up_tgt   = wb_tgt_q;
        end
    end

    assign up_hit    = up_valid && (up_tag_e == up_tag);
    // inv_all takes priority over a same-cycle update.
    assign up_accept = running && bus.update && !bus.inv_all;

    bpu_sat_cnt2 u_sat_cnt (
        .cnt      (up_cnt),
        .up       (bus.act_taken),
        .cnt_next (up_cnt_next)
    );

    always_comb begin
        wb_vld_d = 1'b0;
        wb_idx_d = up_idx;
        wb_tag_d = up_tag;
        wb_cnt_d = up_cnt_next;
        wb_tgt_d = up_tgt;
        if (up_accept) begin
            if (up_hit) begin
                wb_vld_d = 1'b1;
                if (bus.act_taken) wb_tgt_d = bus.act_target;
            end else if (bus.act_taken) begin
                // Allocate or replace the aliasing entry.
                wb_vld_d = 1'b1;
                wb_cnt_d = CNT_INIT;
                wb_tgt_d = bus.act_target;
            end
        end
    end

    // --------------------------------------------------------------- sweep FSM
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (!rst_n) begin
            state_d = StInit;
            sweep_d = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    sweep_d = sweep_q + IDX_W'(1);
                    if (sweep_q == IDX_W'(DEPTH - 1)) state_d = StRun;
                end
                StRun: begin
                    if (bus.inv_all) begin
                        state_d = StInit;
                        sweep_d = '0;
                    end
                end
                default: begin
                    state_d = StInit;
                    sweep_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StInit;
            sweep_q  <= '0;
            wb_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            wb_vld_q <= wb_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        wb_idx_q <= wb_idx_d;
        wb_tag_q <= wb_tag_d;
        wb_cnt_q <= wb_cnt_d;
        wb_tgt_q <= wb_tgt_d;
    end

    // ------------------------------------------------------------ table write
    always_ff @(posedge clk) begin
        if (wb_vld_q) begin
            valid_q[wb_idx_q] <= 1'b1;
            tag_mem[wb_idx_q] <= wb_tag_q;
            cnt_mem[wb_idx_q] <= wb_cnt_q;
            tgt_mem[wb_idx_q] <= wb_tgt_q;
        end
        // Sweep clear comes last so it wins over a stale buffered write.
        if (rst_n && (state_q == StInit)) begin
            valid_q[sweep_q] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpu_btb.sv
// Directed self-checking bench for bpu_btb.
module tb_bpu_btb;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bpu_btb_if bif ();

    bpu_btb #(
        .IDX_W    (6),
        .TAG_W    (24),
        .CNT_INIT (2'b10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the update is sampled at the following posedge.
    task automatic do_update(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
        bif.update     = 1'b1;
        bif.update_pc  = upc;
        bif.act_taken  = tk;
        bif.act_target = tgt;
        @(negedge clk);
        bif.update     = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] lpc, input logic exp_tk,
                          input logic [31:0] exp_tgt);
        bif.pc = lpc;
        #1;
        check({tag, "_tk"}, {31'd0, bif.pred_taken}, {31'd0, exp_tk});
        check({tag, "_tgt"}, bif.pred_target, exp_tgt);
    endtask

    // Counts negedges with init_busy high, starting at the current one. Mid-sweep it
    // checks that a trained pc is not predicted and injects an update that must be dropped.
    task automatic measure_busy(input string tag);
        int cnt;
        cnt = 0;
        while (bif.init_busy && cnt < 200) begin
            cnt++;
            if (cnt == 10) begin
                bif.pc = 32'h8000_0040;
                #1;
                check({tag, "_sweep_pred"}, {31'd0, bif.pred_taken}, 32'd0);
            end
            if (cnt == 30) begin
                bif.update     = 1'b1;
                bif.update_pc  = 32'h8000_0300;
                bif.act_taken  = 1'b1;
                bif.act_target = 32'h8000_0400;
            end else begin
                bif.update = 1'b0;
            end
            @(negedge clk);
        end
        bif.update = 1'b0;
        check({tag, "_busy_len"}, cnt, 32'd64);
        check({tag, "_busy_end"}, {31'd0, bif.init_busy}, 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bif.pc         = '0;
        bif.update     = 1'b0;
        bif.update_pc  = '0;
        bif.act_taken  = 1'b0;
        bif.act_target = '0;
        bif.inv_all    = 1'b0;

        // 1. reset
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bif.init_busy}, 32'd1);
        lookup("rst_pred", 32'h8000_0100, 1'b0, 32'd0);
        rst_n = 1'b1;
        measure_busy("init");
        lookup("cold_miss", 32'h8000_0100, 1'b0, 32'd0);
        // the update injected during the sweep must have been dropped
        lookup("init_drop", 32'h8000_0300, 1'b0, 32'd0);

        // 2. allocation and aliasing (0x80000100 / 0x80001100 share index 0)
        do_update(32'h8000_0100, 1'b1, 32'h8000_0200);
        lookup("alloc_hit", 32'h8000_0100, 1'b1, 32'h8000_0200);
        lookup("alias_miss", 32'h8000_1100, 1'b0, 32'd0);

        // 3. hysteresis: 10 -> 01 -> 00 -> 00, then 01 -> 10
        do_update(32'h8000_0100, 1'b0, 32'd0);
        lookup("nt1", 32'h8000_0100, 1'b0, 32'd0);
        do_update(32'h8000_0100, 1'b0, 32'd0);
        lookup("nt2", 32'h8000_0100, 1'b0, 32'd0);
        do_update(32'h8000_0100, 1'b0, 32'd0);
        lookup("nt3_sat", 32'h8000_0100, 1'b0, 32'd0);
        do_update(32'h8000_0100, 1'b1, 32'h8000_0204);
        lookup("t1", 32'h8000_0100, 1'b0, 32'd0);
        do_update(32'h8000_0100, 1'b1, 32'h8000_0208);
        lookup("t2", 32'h8000_0100, 1'b1, 32'h8000_0208);

        // 4. back-to-back updates: 10 -> 01, then taken,taken -> 10 -> 11
        do_update(32'h8000_0100, 1'b0, 32'd0);
        lookup("pre_b2b", 32'h8000_0100, 1'b0, 32'd0);
        bif.update     = 1'b1;
        bif.update_pc  = 32'h8000_0100;
        bif.act_taken  = 1'b1;
        bif.act_target = 32'h8000_0210;
        @(negedge clk);
        bif.act_target = 32'h8000_0214;
        @(negedge clk);
        bif.update     = 1'b0;
        lookup("b2b_t", 32'h8000_0100, 1'b1, 32'h8000_0214);
        // not-taken pair back-to-back: 11 -> 10 -> 01
        bif.update    = 1'b1;
        bif.act_taken = 1'b0;
        @(negedge clk);
        lookup("b2b_nt1", 32'h8000_0100, 1'b1, 32'h8000_0214);
        @(negedge clk);
        bif.update = 1'b0;
        lookup("b2b_nt2", 32'h8000_0100, 1'b0, 32'd0);
        do_update(32'h8000_0100, 1'b1, 32'h8000_0220);
        lookup("retrain", 32'h8000_0100, 1'b1, 32'h8000_0220);
        do_update(32'h8000_0040, 1'b1, 32'h0000_1234);
        lookup("idx16_hit", 32'h8000_0040, 1'b1, 32'h0000_1234);

        // 5. inv_all and update in the same cycle
        bif.inv_all    = 1'b1;
        bif.update     = 1'b1;
        bif.update_pc  = 32'h8000_0300;
        bif.act_taken  = 1'b1;
        bif.act_target = 32'h8000_0400;
        @(negedge clk);
        bif.inv_all = 1'b0;
        bif.update  = 1'b0;
        measure_busy("inv");
        lookup("inv_miss_100", 32'h8000_0100, 1'b0, 32'd0);
        lookup("inv_miss_040", 32'h8000_0040, 1'b0, 32'd0);
        lookup("inv_miss_300", 32'h8000_0300, 1'b0, 32'd0);

        // 6. reset in the middle of a sweep
        do_update(32'h8000_0040, 1'b1, 32'h0000_5678);
        lookup("pre_inv2", 32'h8000_0040, 1'b1, 32'h0000_5678);
        bif.inv_all = 1'b1;
        @(negedge clk);
        bif.inv_all = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, bif.init_busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        measure_busy("mid_rst");
        lookup("post_rst_miss", 32'h8000_0040, 1'b0, 32'd0);
        do_update(32'h8000_0300, 1'b1, 32'h8000_0500);
        lookup("post_rst_alloc", 32'h8000_0300, 1'b1, 32'h8000_0500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
